cpu_step_4_dcache: RTL
======================

# cpu_step_4_dcache

Parametrised direct-mapped data cache for pipeline step 4 (memory access). Handles hit lookup, line refill on read miss and write-through stores with its own state machine; it drives the stall signal to the pipeline and talks to backing memory over a single-word req/ack port. This replaces externally sequenced tag/index/offset/load-bus control with internal sequencing.

## Interface
- WIDTH, 32, data word width
- ADDR_W, 5, word-address width
- LINES, 4, number of cache lines (power of 2)
- WORDS, 4, words per line (power of 2)
- CNT_W, 16, miss-counter width
- derived: IDX_W = log2(LINES), OFF_W = log2(WORDS), TAG_W = ADDR_W - IDX_W - OFF_W; TAG_W ≥ 1 is required.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- cpu_rd  in  1  load request
- cpu_wr  in  1  store request
- cpu_addr  in  ADDR_W  word address {tag, index, offset}
- cpu_wdata  in  WIDTH  store data
- cpu_rdata  out  WIDTH  load data, valid when cpu_rd & hit
- hit  out  1  lookup hit (valid & tag match), combinational
- stall  out  1  pipeline must hold cpu_* stable while high
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- miss_count  out  CNT_W  saturating read-miss counter

## Operation
- Store arrays: valid[LINES], tag[LINES], data[LINES×WORDS].
- FSM states: IDLE, REFILL, WRITE.
- IDLE, cpu_wr=1 (takes priority over cpu_rd): if hit, write cpu_wdata into data array at this edge; → WRITE. No allocation on write miss.
- IDLE, cpu_rd=1, hit: no state change, cpu_rdata = data[index][offset].
- IDLE, cpu_rd=1, miss: → REFILL, refill counter = 0, miss_count += 1 (saturating at all-ones).
- REFILL: mem_req=1, mem_we=0, mem_addr = {tag, index, counter}. On mem_ack, write mem_rdata to data[index][counter], counter += 1. On ack with counter = WORDS-1: set valid[index]=1, tag[index]=cpu tag, → IDLE.
- WRITE: mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata; on mem_ack → IDLE.
- stall = (IDLE & cpu_wr) | (IDLE & cpu_rd & ~hit) | (state ≠ IDLE).
- Refill always fetches offsets 0..WORDS-1 in order regardless of requested offset; counter wraps to 0 after last word.
- mem_ack outside REFILL/WRITE is ignored.

## Timing
- Reset (rst=0 at edge): state=IDLE, all valid=0, counter=0, miss_count=0, mem_req=0, mem_we=0; mem_addr/mem_wdata=0. While rst=0, hit=0 and stall=0.
- Reset mid-refill/write: abandons transaction at that edge; line not validated; mem_req low from next cycle.
- Read hit: 0-cycle latency, no stall.
- Read miss: stall from request cycle; line refilled after WORDS acks; hit and stall drop the cycle after final ack (lookup re-evaluated in IDLE). Minimum penalty WORDS+1 cycles with ack-every-cycle memory.
- Store: stall from request cycle until cycle after mem_ack; minimum 2 cycles.
- mem_req/mem_we/mem_addr/mem_wdata are registered, held stable until mem_ack is sampled; in REFILL the next address is presented the cycle after each ack with mem_req kept high.
- Back-to-back accesses: a new request is accepted the cycle after return to IDLE.

## Structure
- Package cpu_cache_pkg: FSM state enum, width-derivation localparams, address field extraction functions.
- Sub-module cache_line_store: valid/tag/data arrays with one read port (index, offset) and one word write port plus line-validate strobe; FSM and memory port stay in top.

## Test plan
- Reset then read addr 0x05 (LINES=4, WORDS=4, memory word n = n+100): miss, stall 5 cycles with ack-every-cycle, mem_addr 0x04..0x07, then cpu_rdata=105, miss_count=1.
- Read 0x06 after above: hit in same cycle, stall=0, rdata=106, miss_count unchanged.
- Read 0x15 (same index, tag 1): miss, line replaced, rdata=121; reread 0x05 misses again, miss_count=3.
- Store 0xDEAD to cached 0x07: mem write seen with addr 0x07; subsequent read 0x07 hits with 0xDEAD. Store to uncached 0x1C: memory written, read 0x1C still misses.
- Memory ack delayed 3 cycles per word: mem_req/addr stable across wait, stall held throughout; assert rst=0 after second word: valid cleared, next read of same line misses.
- Force 2^CNT_W+2 misses (CNT_W=4 override): miss_count saturates at 15.

Source files
------------

// File: rtl/cpu_cache_pkg.sv
// Shared types and address helpers for the step-4 data cache.
package cpu_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE
  } state_t;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_LINES  = 4;
  localparam int unsigned DEF_WORDS  = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned lines,
                                            input int unsigned words);
    return addr_w - $clog2(lines) - $clog2(words);
  endfunction

  // Extracts a width-bit field starting at lsb; callers cast to the field size.
  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cpu_step_4_dcache_line_store.sv
// Valid/tag/data arrays: one combinational read port, one word write port, one line-validate port.
module cache_line_store #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LINES = 4,
  parameter int unsigned WORDS = 4,
  parameter int unsigned TAG_W = 1,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned OFF_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [OFF_W-1:0] i_rd_off,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [OFF_W-1:0] i_wr_off,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_val_en,
  input  logic [IDX_W-1:0] i_val_idx,
  input  logic [TAG_W-1:0] i_val_tag
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [WIDTH-1:0] r_data [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_val_en) begin
      r_valid[i_val_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_val_en) begin
      r_tag[i_val_idx] <= i_val_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];

endmodule

// File: rtl/cpu_step_4_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with internal refill sequencing.
module cpu_step_4_dcache
  import cpu_cache_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LINES  = DEF_LINES,
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic [WIDTH-1:0]  cpu_rdata,
  output logic              hit,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned TAG_W = tag_width(ADDR_W, LINES, WORDS);

  state_t            r_state, w_state_nxt;
  logic [OFF_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0]  r_miss;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [WIDTH-1:0]  r_mem_wdata, w_mem_wdata_nxt;

  logic [TAG_W-1:0]  w_tag, w_line_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off, w_wr_off;
  logic              w_line_valid, w_hit;
  logic              w_wr_en, w_val_en, w_miss_inc;
  logic [WIDTH-1:0]  w_wr_data;

  assign w_off = OFF_W'(addr_field(32'(cpu_addr), 0, OFF_W));
  assign w_idx = IDX_W'(addr_field(32'(cpu_addr), OFF_W, IDX_W));
  assign w_tag = TAG_W'(addr_field(32'(cpu_addr), IDX_W + OFF_W, TAG_W));

  cache_line_store #(
    .WIDTH(WIDTH),
    .LINES(LINES),
    .WORDS(WORDS),
    .TAG_W(TAG_W),
    .IDX_W(IDX_W),
    .OFF_W(OFF_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .i_rd_idx  (w_idx),
    .i_rd_off  (w_off),
    .o_rd_valid(w_line_valid),
    .o_rd_tag  (w_line_tag),
    .o_rd_data (cpu_rdata),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_idx),
    .i_wr_off  (w_wr_off),
    .i_wr_data (w_wr_data),
    .i_val_en  (w_val_en),
    .i_val_idx (w_idx),
    .i_val_tag (w_tag)
  );

  // Lookup is forced off during reset so the pipeline sees neither hit nor stall.
  assign w_hit     = rst && w_line_valid && (w_line_tag == w_tag);
  assign hit       = w_hit;
  assign stall     = rst && ((r_state != ST_IDLE) ||
                             cpu_wr || (cpu_rd && !w_hit));
  assign w_cnt_inc = r_cnt + OFF_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_wr_en         = 1'b0;
    w_wr_off        = w_off;
    w_wr_data       = cpu_wdata;
    w_val_en        = 1'b0;
    w_miss_inc      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cpu_wr) begin
          w_wr_en         = w_hit;
          w_state_nxt     = ST_WRITE;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = cpu_addr;
          w_mem_wdata_nxt = cpu_wdata;
        end else if (cpu_rd && !w_hit) begin
          w_state_nxt    = ST_REFILL;
          w_cnt_nxt      = '0;
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = {w_tag, w_idx, {OFF_W{1'b0}}};
          w_miss_inc     = 1'b1;
        end
      end
      ST_REFILL: begin
        if (mem_ack) begin
          w_wr_en        = 1'b1;
          w_wr_off       = r_cnt;
          w_wr_data      = mem_rdata;
          w_cnt_nxt      = w_cnt_inc;
          w_mem_addr_nxt = {w_tag, w_idx, w_cnt_inc};
          if (r_cnt == OFF_W'(WORDS - 1)) begin
            w_val_en      = 1'b1;
            w_state_nxt   = ST_IDLE;
            w_mem_req_nxt = 1'b0;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!rst) begin
      w_wr_en  = 1'b0;
      w_val_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_miss      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_miss_inc && (r_miss != '1)) begin
        r_miss <= r_miss + CNT_W'(1);
      end
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign miss_count = r_miss;

endmodule
